cpu_run_ctrl: RTL and testbench

Boot, run and debug sequencer for the single-cycle CPU. It loads a program into IMEM from an external byte stream, then holds the CPU in reset for a fixed interval. After that it drives the CPU's ena input to run freely, halt, single-step or stop on a PC breakpoint. It sits between the top level, the CPU (ena/rst/out_pc) and the IMEM write port, and counts retired instructions.

---
 rtl/cpu_run_ctrl_pkg.sv | 16 +
 rtl/cpu_run_ctrl_imem_loader.sv | 86 ++++++++
 rtl/cpu_run_ctrl.sv | 113 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state encoding, address base and byte-lane order for the run controller
package cpu_run_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CRST = 3'd2,
    ST_RUN  = 3'd3,
    ST_HALT = 3'd4,
    ST_STEP = 3'd5
  } state_t;
  localparam logic [31:0] PC_BASE_DEF = 32'h0040_0000;
  localparam bit LANE_LE = 1'b1;
  function automatic logic [1:0] lane_of(input logic [1:0] idx);
    return LANE_LE ? idx : 2'd3 - idx;
  endfunction
endpackage

// File: rtl/cpu_run_ctrl_imem_loader.sv
// cpu_run_ctrl_imem_loader: assembles loader bytes into IMEM words, writes them and flags overflow
module cpu_run_ctrl_imem_loader
  import cpu_run_ctrl_pkg::*;
#(
  parameter int IMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               first,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  input  logic               in_last,
  output logic               in_ready,
  output logic               we,
  output logic [IMEM_AW-1:0] addr,
  output logic [31:0]        wdata,
  output logic               done,
  output logic               ovf,
  output logic               err
);
  logic [1:0]         idx_q, idx_d, idx_b;
  logic [IMEM_AW:0]   ptr_q, ptr_d, ptr_b;
  logic [31:0]        buf_q, buf_d, word, wdata_q, wdata_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic               we_q, we_d, done_q, done_d, ovf_q, ovf_d, err_q, err_d, acc, flush;
  assign in_ready = en & ~done_q & ~ovf_q;
  assign acc      = in_valid & in_ready;
  assign idx_b    = first ? 2'd0 : idx_q;
  assign ptr_b    = first ? '0 : ptr_q;
  assign flush    = acc & ((idx_b == 2'd3) | in_last);
  always_comb begin
    word = (idx_b == 2'd0) ? 32'd0 : buf_q;
    word[{lane_of(idx_b), 3'b000} +: 8] = in_byte;
    buf_d   = acc ? word : buf_q;
    idx_d   = flush ? 2'd0 : acc ? idx_b + 2'd1 : idx_q;
    ptr_d   = acc ? ptr_b : ptr_q;
    err_d   = (acc & first) ? 1'b0 : err_q;
    we_d    = 1'b0;
    ovf_d   = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (flush) begin
      if (ptr_b[IMEM_AW]) begin
        ovf_d = 1'b1;
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_b[IMEM_AW-1:0];
        wdata_d = word;
        ptr_d   = ptr_b + (IMEM_AW+1)'(1);
        done_d  = in_last;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      ptr_q   <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
  assign we    = we_q;
  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign err   = err_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: boot/run/debug sequencer driving CPU enable and reset, IMEM loading and retire count
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int          IMEM_AW    = 10,
  parameter int          RST_CYCLES = 4,
  parameter logic [31:0] PC_BASE    = PC_BASE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [7:0]         load_byte,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               start,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               step_req,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic [31:0]        cpu_pc,
  output logic               cpu_ena,
  output logic               cpu_rst,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic [2:0]         state_o,
  output logic               load_err,
  output logic [31:0]        instr_cnt
);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  if (RST_CYCLES < 1 || PC_BASE[1:0] != 2'b00) begin : g_bad_param
    $error("cpu_run_ctrl: RST_CYCLES must be >= 1 and PC_BASE word aligned");
  end
  state_t            state_q, state_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [31:0]       instr_cnt_q, instr_cnt_d;
  logic              bp_skip_q, bp_skip_d, bp_hit, ld_en, ld_ready, ld_done, ld_ovf, acc;
  assign ld_en      = (state_q == ST_IDLE) | (state_q == ST_LOAD);
  assign load_ready = rst & ld_en & ld_ready;
  assign acc        = load_valid & load_ready;
  assign bp_hit     = bp_en & (cpu_pc == bp_addr) & ~bp_skip_q;
  cpu_run_ctrl_imem_loader #(.IMEM_AW(IMEM_AW)) u_loader (
    .clk      (clk),
    .rst      (rst),
    .en       (ld_en),
    .first    (state_q == ST_IDLE),
    .in_valid (load_valid),
    .in_byte  (load_byte),
    .in_last  (load_last),
    .in_ready (ld_ready),
    .we       (imem_we),
    .addr     (imem_addr),
    .wdata    (imem_wdata),
    .done     (ld_done),
    .ovf      (ld_ovf),
    .err      (load_err)
  );
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    bp_skip_d = bp_skip_q;
    cpu_rst   = 1'b1;
    cpu_ena   = 1'b0;
    case (state_q)
      ST_IDLE: state_d = acc ? ST_LOAD : start ? ST_CRST : ST_IDLE;
      ST_LOAD: state_d = ld_done ? ST_CRST : ld_ovf ? ST_IDLE : ST_LOAD;
      ST_CRST: begin
        rcnt_d  = rcnt_q + RC_W'(1);
        state_d = (rcnt_q == RC_W'(RST_CYCLES - 1)) ? ST_RUN : ST_CRST;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        cpu_ena = ~(halt_req | bp_hit);
        state_d = cpu_ena ? ST_RUN : ST_HALT;
      end
      ST_HALT: begin
        cpu_rst = 1'b0;
        if (step_req | (resume & ~halt_req)) begin
          state_d   = step_req ? ST_STEP : ST_RUN;
          bp_skip_d = 1'b1;
        end
      end
      ST_STEP: begin
        cpu_rst = 1'b0;
        cpu_ena = 1'b1;
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cpu_ena) bp_skip_d = 1'b0;
    if (state_d == ST_CRST && state_q != ST_CRST) begin
      rcnt_d    = '0;
      bp_skip_d = 1'b0;
    end
    instr_cnt_d = (state_d == ST_CRST) ? 32'd0 : instr_cnt_q + 32'(cpu_ena);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rcnt_q      <= '0;
      instr_cnt_q <= '0;
      bp_skip_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      instr_cnt_q <= instr_cnt_d;
      bp_skip_q   <= bp_skip_d;
    end
  end
  assign state_o   = state_q;
  assign instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized scenario bench for cpu_run_ctrl with a behavioural CPU and IMEM model
module tb_cpu_run_ctrl;
  localparam int          AW   = 2;
  localparam int          RC   = 4;
  localparam logic [31:0] BASE = 32'h0040_0000;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0, load_last = 1'b0, start = 1'b0, halt_req = 1'b0;
  logic          resume = 1'b0, step_req = 1'b0, bp_en = 1'b0;
  logic [7:0]    load_byte = 8'h00;
  logic [31:0]   bp_addr = 32'h0;
  logic [31:0]   pc;
  logic          load_ready, cpu_ena, cpu_rst, imem_we, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, instr_cnt;
  logic [2:0]    state_o;
  logic [7:0]    stream[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            errors = 0;
  int            checks = 0;
  cpu_run_ctrl #(.IMEM_AW(AW), .RST_CYCLES(RC), .PC_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .start(start), .halt_req(halt_req), .resume(resume), .step_req(step_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .cpu_pc(pc), .cpu_ena(cpu_ena), .cpu_rst(cpu_rst),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .state_o(state_o),
    .load_err(load_err), .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) pc <= BASE;
    else if (cpu_rst) pc <= BASE;
    else if (cpu_ena) pc <= pc + 32'd4;
  always @(negedge clk)
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4; j++)
      if (4 * i + j < stream.size()) w = w | (32'(stream[4 * i + j]) << (8 * j));
    return w;
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    {load_valid, load_last, start, halt_req, resume, step_req, bp_en} = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic rand_stream(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
  endtask
  task automatic send_stream(input string nm);
    for (int i = 0; i < stream.size(); i++) begin
      int w = 0;
      load_valid = 1'b1;
      load_byte  = stream[i];
      load_last  = (i == stream.size() - 1);
      while (!load_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w >= 20) begin
        checks++;
        errors++;
        $display("FAIL %s byte_accept_timeout: byte %0d never accepted within 20 cycles", nm, i);
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask
  task automatic expect_boot(input string nm);
    int n = 0;
    int t = 0;
    while (state_o != 3'd3 && t < 40) begin
      if (state_o == 3'd2) begin
        n++;
        checks++;
        if (cpu_rst !== 1'b1 || cpu_ena !== 1'b0) begin
          errors++;
          $display("FAIL %s crst_outputs: rst=%b ena=%b want rst=1 ena=0", nm, cpu_rst, cpu_ena);
        end
      end
      @(negedge clk);
      t++;
    end
    checks++;
    if (n != RC) begin
      errors++;
      $display("FAIL %s crst_length: got %0d cycles want %0d", nm, n, RC);
    end
    checks++;
    if (state_o !== 3'd3 || cpu_ena !== 1'b1 || cpu_rst !== 1'b0 || instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s run_entry: state=%0d ena=%b rst=%b cnt=%0d want state=3 ena=1 rst=0 cnt=0",
               nm, state_o, cpu_ena, cpu_rst, instr_cnt);
    end
  endtask
  task automatic check_writes(input string nm, input int nexp);
    checks++;
    if (wa_q.size() != nexp) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", nm, wa_q.size(), nexp);
    end
    for (int i = 0; i < wa_q.size() && i < nexp; i++) begin
      checks++;
      if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL %s write_%0d: got addr=%0d data=%h want addr=%0d data=%h",
                 nm, i, wa_q[i], wd_q[i], i, exp_word(i));
      end
    end
  endtask
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if (state_o !== 3'd0 || cpu_rst !== 1'b1 || cpu_ena !== 1'b0 || imem_we !== 1'b0 ||
        imem_addr !== '0 || imem_wdata !== 32'd0 || load_ready !== 1'b0 || load_err !== 1'b0 ||
        instr_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: state=%0d rst=%b ena=%b we=%b addr=%0d wdata=%h ready=%b err=%b cnt=%0d",
               state_o, cpu_rst, cpu_ena, imem_we, imem_addr, imem_wdata, load_ready, load_err, instr_cnt);
    end
    cyc(2);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 3'd0 || load_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d ready=%b rst=%b want 0 1 1", state_o, load_ready, cpu_rst);
    end
  endtask
  task automatic test_load;
    wa_q.delete();
    wd_q.delete();
    stream = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    send_stream("load");
    expect_boot("load");
    check_writes("load", 2);
    checks++;
    if (wd_q.size() < 2 || wd_q[0] !== 32'h1234_5678 || wd_q[1] !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL load_words: got %0d words first=%h want 12345678 0000beef",
               wd_q.size(), wd_q.size() > 0 ? wd_q[0] : 32'hx);
    end
  endtask
  task automatic test_random_load;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      wa_q.delete();
      wd_q.delete();
      rand_stream($urandom_range(1, 16));
      send_stream("rand_load");
      expect_boot("rand_load");
      check_writes("rand_load", (stream.size() + 3) / 4);
      checks++;
      if (load_err !== 1'b0) begin
        errors++;
        $display("FAIL rand_load_err: got %b want 0", load_err);
      end
    end
  endtask
  task automatic test_overflow;
    do_reset();
    wa_q.delete();
    wd_q.delete();
    rand_stream($urandom_range(17, 20));
    send_stream("overflow");
    cyc(4);
    check_writes("overflow", 4);
    checks++;
    if (load_err !== 1'b1 || state_o !== 3'd0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: err=%b state=%0d rst=%b want 1 0 1", load_err, state_o, cpu_rst);
    end
    wa_q.delete();
    wd_q.delete();
    rand_stream(4);
    send_stream("reload");
    expect_boot("reload");
    check_writes("reload", 1);
    checks++;
    if (load_err !== 1'b0) begin
      errors++;
      $display("FAIL reload_err_clear: got %b want 0", load_err);
    end
  endtask
  task automatic test_breakpoint(output int cnt_after);
    int k;
    logic found = 1'b0;
    do_reset();
    k = $urandom_range(2, 7);
    bp_en = 1'b1;
    bp_addr = BASE + 32'(4 * k);
    pulse_start();
    expect_boot("bp");
    for (int t = 0; t < 40; t++) begin
      if (state_o == 3'd3 && pc == bp_addr) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found || cpu_ena !== 1'b0 || instr_cnt !== 32'(k)) begin
      errors++;
      $display("FAIL bp_hit: found=%b ena=%b cnt=%0d want found=1 ena=0 cnt=%0d", found, cpu_ena, instr_cnt, k);
    end
    @(negedge clk);
    checks++;
    if (state_o !== 3'd4 || pc !== bp_addr || instr_cnt !== 32'(k)) begin
      errors++;
      $display("FAIL bp_halt: state=%0d pc=%h cnt=%0d want 4 %h %0d", state_o, pc, instr_cnt, bp_addr, k);
    end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    checks++;
    if (state_o !== 3'd3 || cpu_ena !== 1'b1 || pc !== bp_addr) begin
      errors++;
      $display("FAIL bp_resume: state=%0d ena=%b pc=%h want 3 1 %h", state_o, cpu_ena, pc, bp_addr);
    end
    @(negedge clk);
    checks++;
    if (pc !== bp_addr + 32'd4 || instr_cnt !== 32'(k + 1) || cpu_ena !== 1'b1) begin
      errors++;
      $display("FAIL bp_past: pc=%h cnt=%0d ena=%b want %h %0d 1", pc, instr_cnt, cpu_ena, bp_addr + 32'd4, k + 1);
    end
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    cnt_after = k + 1;
  endtask
  task automatic test_step(input int base);
    logic [31:0] pc0 = pc;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      checks++;
      if (state_o !== 3'd5 || cpu_ena !== 1'b1) begin
        errors++;
        $display("FAIL step_%0d_pulse: state=%0d ena=%b want 5 1", i, state_o, cpu_ena);
      end
      @(negedge clk);
      checks++;
      if (state_o !== 3'd4 || cpu_ena !== 1'b0 || instr_cnt !== 32'(base + i + 1)) begin
        errors++;
        $display("FAIL step_%0d_halt: state=%0d ena=%b cnt=%0d want 4 0 %0d", i, state_o, cpu_ena, instr_cnt, base + i + 1);
      end
      cyc(3);
    end
    checks++;
    if (pc !== pc0 + 32'd12 || state_o !== 3'd4) begin
      errors++;
      $display("FAIL step_pc: pc=%h state=%0d want %h 4", pc, state_o, pc0 + 32'd12);
    end
  endtask
  task automatic test_halt_priority;
    int m;
    do_reset();
    pulse_start();
    expect_boot("prio");
    m = $urandom_range(1, 10);
    cyc(m);
    halt_req = 1'b1;
    step_req = 1'b1;
    #1;
    checks++;
    if (cpu_ena !== 1'b0 || instr_cnt !== 32'(m)) begin
      errors++;
      $display("FAIL prio_halt_cycle: ena=%b cnt=%0d want 0 %0d", cpu_ena, instr_cnt, m);
    end
    @(negedge clk);
    step_req = 1'b0;
    checks++;
    if (state_o !== 3'd4 || instr_cnt !== 32'(m)) begin
      errors++;
      $display("FAIL prio_halt_only: state=%0d cnt=%0d want 4 %0d", state_o, instr_cnt, m);
    end
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    checks++;
    if (state_o !== 3'd4 || cpu_ena !== 1'b0) begin
      errors++;
      $display("FAIL prio_resume_blocked: state=%0d ena=%b want 4 0", state_o, cpu_ena);
    end
    halt_req = 1'b0;
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    checks++;
    if (state_o !== 3'd3 || cpu_ena !== 1'b1) begin
      errors++;
      $display("FAIL prio_resume: state=%0d ena=%b want 3 1", state_o, cpu_ena);
    end
    @(negedge clk);
    checks++;
    if (instr_cnt !== 32'(m + 1)) begin
      errors++;
      $display("FAIL prio_count: got %0d want %0d", instr_cnt, m + 1);
    end
  endtask
  task automatic test_load_in_run;
    do_reset();
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    expect_boot("run_load");
    load_valid = 1'b1;
    load_byte  = 8'h5A;
    #1;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_load_ready: got %b want 0", load_ready);
    end
    cyc(3);
    load_valid = 1'b0;
    checks++;
    if (wa_q.size() != 0 || state_o !== 3'd3 || instr_cnt !== 32'd3) begin
      errors++;
      $display("FAIL run_load_ignored: writes=%0d state=%0d cnt=%0d want 0 3 3", wa_q.size(), state_o, instr_cnt);
    end
  endtask
  task automatic test_async_reset;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || cpu_rst !== 1'b1 || cpu_ena !== 1'b0 || instr_cnt !== 32'd0 ||
        load_ready !== 1'b0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_run: state=%0d rst=%b ena=%b cnt=%0d ready=%b we=%b want 0 1 0 0 0 0",
               state_o, cpu_rst, cpu_ena, instr_cnt, load_ready, imem_we);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    load_valid = 1'b1;
    load_byte  = 8'hAA;
    @(negedge clk);
    load_byte  = 8'hBB;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL partial_load_state: got %0d want 1", state_o);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_load: state=%0d we=%b want 0 0", state_o, imem_we);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    rand_stream(4);
    send_stream("post_abort");
    expect_boot("post_abort");
    check_writes("post_abort", 1);
  endtask
  initial begin
    int c;
    test_reset();
    test_load();
    test_random_load();
    test_overflow();
    test_breakpoint(c);
    test_step(c);
    test_halt_priority();
    test_load_in_run();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
